dual_rail_precharge_pipe: RTL and testbench

- Parametrised WIDTH-bit dual-rail (true/false rail) sampling pipeline with a precharge/evaluate output stage.
- Generalises the single-bit two-level precharge flip-flop: configurable width and sampling depth, internal or external phase control, code checking and fault counting.
- Sits between dual-rail logic stages of the AES datapath. It presents evaluate data and all-zero spacer (precharge) waves, each lasting whole clock cycles.

---
 rtl/dual_rail_precharge_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_dual_rail_precharge_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_precharge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dual_rail_precharge_pipe
// Purpose  : WIDTH-bit dual-rail (true/false rail) sampling pipeline with a
//            precharge/evaluate output stage. The output alternates between
//            evaluate waves (sampled data) and all-zero spacer waves, each
//            lasting whole clock cycles. The phase comes either from an
//            internal two-state FSM or from an external control input.
//            The code captured into the first sampling stage is checked
//            every edge; t=f=1 on any bit sets a sticky fault flag and bumps
//            a saturating fault counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        number of dual-rail bits
//   DEPTH        sampling stages ahead of the output stage (>= 1)
//   EXT_PHASE    1 = phase taken from Precharge_in, 0 = internal phase FSM
//   PRE_CYCLES   precharge phase length in cycles (>= 1, internal mode)
//   EVAL_CYCLES  evaluate phase length in cycles (>= 1, internal mode)
//   CNT_W        fault counter width
// Ports
//   CLK           in   1      clock, all state on the rising edge
//   Reset         in   1      synchronous, active-low reset
//   Enable        in   1      internal FSM advance enable (internal mode only)
//   Precharge_in  in   1      external phase, 1 = precharge (external mode)
//   Data_t        in   WIDTH  true rails
//   Data_f        in   WIDTH  false rails
//   Fault_clr     in   1      clears Fault_o and Fault_cnt
//   Q_t           out  WIDTH  output true rails
//   Q_f           out  WIDTH  output false rails
//   Phase_o       out  1      1 = current Q is a precharge wave
//   Valid_o       out  1      1 = Q is evaluate and every bit complementary
//   Fault_o       out  1      sticky invalid-code flag
//   Fault_cnt     out  CNT_W  saturating count of cycles with invalid code
// ============================================================================
module dual_rail_precharge_pipe #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 1,
   parameter int EXT_PHASE   = 0,
   parameter int PRE_CYCLES  = 1,
   parameter int EVAL_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Precharge_in,
   input  logic [WIDTH-1:0] Data_t,
   input  logic [WIDTH-1:0] Data_f,
   input  logic             Fault_clr,
   output logic [WIDTH-1:0] Q_t,
   output logic [WIDTH-1:0] Q_f,
   output logic             Phase_o,
   output logic             Valid_o,
   output logic             Fault_o,
   output logic [CNT_W-1:0] Fault_cnt
);

   // Phase counter must hold values up to max(PRE_CYCLES,EVAL_CYCLES)-1.
   // A one-cycle phase length still gets a 1-bit counter so the vector
   // never collapses to zero width.
   localparam int c_MAX_CYC  = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
   localparam int c_CNT_BITS = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

   // -------------------------------------------------------------------------
   // Sampling stages. Index 0 is the first stage fed from the inputs, index
   // DEPTH-1 feeds the output stage. Reset loads the encoded logic 0
   // (t=0, f=1) so the pipe holds a legal code straight out of reset.
   // The stages shift every cycle independent of phase and Enable.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] r_stage_t [DEPTH];
   logic [WIDTH-1:0] r_stage_f [DEPTH];

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage_t[i] <= '0;
            r_stage_f[i] <= '1;
         end
      end else begin
         r_stage_t[0] <= Data_t;
         r_stage_f[0] <= Data_f;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage_t[i] <= r_stage_t[i-1];
            r_stage_f[i] <= r_stage_f[i-1];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Phase source. w_ph = 1 means the output stage loads a spacer at the
   // coming edge.
   // -------------------------------------------------------------------------
   logic w_ph;

   generate
      if (EXT_PHASE != 0) begin : g_ext_phase
         // External phase is used combinationally at the same edge that
         // updates the output stage.
         assign w_ph = Precharge_in;

         // Enable has no function when the phase is driven externally.
         logic w_unused_enable;
         assign w_unused_enable = Enable;
      end else begin : g_int_phase
         typedef enum logic [0:0] {
            ST_PRE  = 1'b0,
            ST_EVAL = 1'b1
         } state_t;

         localparam logic [c_CNT_BITS-1:0] c_PRE_LAST  = c_CNT_BITS'(PRE_CYCLES - 1);
         localparam logic [c_CNT_BITS-1:0] c_EVAL_LAST = c_CNT_BITS'(EVAL_CYCLES - 1);

         state_t                r_state;
         state_t                w_state_nxt;
         logic [c_CNT_BITS-1:0] r_count;
         logic [c_CNT_BITS-1:0] w_count_nxt;

         // State register; reset aborts any phase in progress and restarts
         // in precharge with a cleared count.
         always_ff @(posedge CLK) begin
            if (!Reset) begin
               r_state <= ST_PRE;
               r_count <= '0;
            end else begin
               r_state <= w_state_nxt;
               r_count <= w_count_nxt;
            end
         end

         // Next-state logic: each phase lasts its configured number of
         // enabled cycles; with Enable low both state and count hold.
         always_comb begin
            w_state_nxt = r_state;
            w_count_nxt = r_count;
            if (Enable) begin
               case (r_state)
                  ST_PRE: begin
                     if (r_count == c_PRE_LAST) begin
                        w_state_nxt = ST_EVAL;
                        w_count_nxt = '0;
                     end else begin
                        w_count_nxt = r_count + 1'b1;
                     end
                  end
                  ST_EVAL: begin
                     if (r_count == c_EVAL_LAST) begin
                        w_state_nxt = ST_PRE;
                        w_count_nxt = '0;
                     end else begin
                        w_count_nxt = r_count + 1'b1;
                     end
                  end
                  default: begin
                     w_state_nxt = ST_PRE;
                     w_count_nxt = '0;
                  end
               endcase
            end
         end

         assign w_ph = (r_state == ST_PRE);

         // The external phase pin has no function in internal mode.
         logic w_unused_precharge;
         assign w_unused_precharge = Precharge_in;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Output stage: spacer (both rails 0) in precharge, last sampling stage
   // in evaluate. Phase_o records which kind of wave Q currently holds.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] r_q_t;
   logic [WIDTH-1:0] r_q_f;
   logic             r_phase;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         r_q_t   <= '0;
         r_q_f   <= '0;
         r_phase <= 1'b1;
      end else begin
         r_phase <= w_ph;
         if (w_ph) begin
            r_q_t <= '0;
            r_q_f <= '0;
         end else begin
            r_q_t <= r_stage_t[DEPTH-1];
            r_q_f <= r_stage_f[DEPTH-1];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Code check. The code is checked as it is captured into the first
   // sampling stage, so a fault is reported at the same edge that stores it.
   // A (0,0) bit is a spacer and is not a fault.
   // Set has priority over clear: an invalid code arriving together with
   // Fault_clr leaves the flag set and the counter at exactly one.
   // -------------------------------------------------------------------------
   logic             w_invalid;
   logic             r_fault;
   logic [CNT_W-1:0] r_fault_cnt;

   assign w_invalid = |(Data_t & Data_f);

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         r_fault     <= 1'b0;
         r_fault_cnt <= '0;
      end else if (w_invalid) begin
         r_fault <= 1'b1;
         if (Fault_clr) begin
            r_fault_cnt <= CNT_W'(1);
         end else if (r_fault_cnt != {CNT_W{1'b1}}) begin
            r_fault_cnt <= r_fault_cnt + 1'b1;
         end
      end else if (Fault_clr) begin
         r_fault     <= 1'b0;
         r_fault_cnt <= '0;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign Q_t       = r_q_t;
   assign Q_f       = r_q_f;
   assign Phase_o   = r_phase;
   assign Fault_o   = r_fault;
   assign Fault_cnt = r_fault_cnt;

   // Valid only for an evaluate wave whose every bit is a legal 0 or 1.
   assign Valid_o   = ~r_phase & (&(r_q_t ^ r_q_f));

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_precharge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_rail_precharge_pipe
// Purpose  : Self-checking bench for dual_rail_precharge_pipe. Three
//            instances cover the default configuration, a deep externally
//            phased pipe, and an unequal-phase FSM with a narrow counter.
//            Stimulus pushes expected values tagged with the edge after
//            which they must hold; a monitor compares them on the falling
//            edge of that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_rail_precharge_pipe;

   localparam int S_Q0   = 0;
   localparam int S_PH0  = 1;
   localparam int S_V0   = 2;
   localparam int S_CNT0 = 3;
   localparam int S_FO0  = 4;
   localparam int S_Q1   = 5;
   localparam int S_PH2  = 6;
   localparam int S_FO2  = 7;
   localparam int S_CNT2 = 8;
   localparam int S_PH1  = 9;

   logic CLK = 1'b0;
   logic Reset;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // u0: defaults
   logic       en0, clr0;
   logic [7:0] d0t, d0f, q0t, q0f;
   logic       ph0, v0, fo0;
   logic [7:0] cnt0;
   // u1: DEPTH=3, external phase
   logic       p1;
   logic [7:0] d1t, d1f, q1t, q1f;
   logic       ph1, v1, fo1;
   logic [7:0] cnt1;
   // u2: PRE=2, EVAL=3, CNT_W=2
   logic       en2, clr2;
   logic [7:0] d2t, d2f, q2t, q2f;
   logic       ph2, v2, fo2;
   logic [1:0] cnt2;
   logic       one = 1'b1;
   logic       zero = 1'b0;

   dual_rail_precharge_pipe u0 (
      .CLK(CLK), .Reset(Reset), .Enable(en0), .Precharge_in(zero),
      .Data_t(d0t), .Data_f(d0f), .Fault_clr(clr0),
      .Q_t(q0t), .Q_f(q0f), .Phase_o(ph0), .Valid_o(v0),
      .Fault_o(fo0), .Fault_cnt(cnt0)
   );

   dual_rail_precharge_pipe #(.DEPTH(3), .EXT_PHASE(1)) u1 (
      .CLK(CLK), .Reset(Reset), .Enable(one), .Precharge_in(p1),
      .Data_t(d1t), .Data_f(d1f), .Fault_clr(zero),
      .Q_t(q1t), .Q_f(q1f), .Phase_o(ph1), .Valid_o(v1),
      .Fault_o(fo1), .Fault_cnt(cnt1)
   );

   dual_rail_precharge_pipe #(.PRE_CYCLES(2), .EVAL_CYCLES(3), .CNT_W(2)) u2 (
      .CLK(CLK), .Reset(Reset), .Enable(en2), .Precharge_in(zero),
      .Data_t(d2t), .Data_f(d2f), .Fault_clr(clr2),
      .Q_t(q2t), .Q_f(q2f), .Phase_o(ph2), .Valid_o(v2),
      .Fault_o(fo2), .Fault_cnt(cnt2)
   );

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void expect_at(input int c, input int s,
                                     input logic [31:0] e, input string n);
      chk_t r;
      r.cyc  = c;
      r.sel  = s;
      r.exp  = e;
      r.name = n;
      sb.push_back(r);
   endfunction

   function automatic logic [31:0] get_sig(input int s);
      case (s)
         S_Q0:    return {16'h0, q0t, q0f};
         S_PH0:   return {31'h0, ph0};
         S_V0:    return {31'h0, v0};
         S_CNT0:  return {24'h0, cnt0};
         S_FO0:   return {31'h0, fo0};
         S_Q1:    return {16'h0, q1t, q1f};
         S_PH2:   return {31'h0, ph2};
         S_FO2:   return {31'h0, fo2};
         S_CNT2:  return {30'h0, cnt2};
         S_PH1:   return {31'h0, ph1};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: on each falling edge, compare every entry due for this cycle.
   always @(negedge CLK) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [31:0] act;
            act = get_sig(sb[i].sel);
            total++;
            if (act !== sb[i].exp) begin
               bad++;
               $display("FAIL %s cyc=%0d: got %h expected %h",
                        sb[i].name, cyc, act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   task automatic goto(input int n);
      do @(negedge CLK); while (cyc < n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      Reset = 1'b0;
      en0 = 1'b1; clr0 = 1'b0; d0t = 8'hFF; d0f = 8'h00;
      p1  = 1'b0; d1t = 8'hFF; d1f = 8'h00;
      en2 = 1'b1; clr2 = 1'b0; d2t = 8'h0F; d2f = 8'hF0;
      expect_at(2, S_Q0,   32'h0000, "reset_q0");
      expect_at(2, S_PH0,  32'h1,    "reset_phase0");
      expect_at(2, S_V0,   32'h0,    "reset_valid0");
      expect_at(2, S_CNT0, 32'h0,    "reset_cnt0");
      expect_at(2, S_FO0,  32'h0,    "reset_fault0");
      expect_at(2, S_Q1,   32'h0000, "reset_q1");
      expect_at(2, S_PH2,  32'h1,    "reset_phase2");

      goto(2);
      Reset = 1'b1;
      d0t = 8'h00; d0f = 8'hFF;
      d1t = 8'h11; d1f = 8'hEE;
      expect_at(3, S_Q0,  32'h0000, "first_pre_q0");
      expect_at(3, S_PH0, 32'h1,    "first_pre_phase0");
      expect_at(3, S_V0,  32'h0,    "first_pre_valid0");
      expect_at(4, S_Q0,  32'h00FF, "first_eval_q0");
      expect_at(4, S_PH0, 32'h0,    "first_eval_phase0");
      expect_at(4, S_V0,  32'h1,    "first_eval_valid0");
      expect_at(3, S_Q1,  32'h00FF, "reset_code_q1");
      expect_at(3, S_PH1, 32'h0,    "ext_eval_phase1");
      expect_at(5, S_Q1,  32'h00FF, "reset_code_tail_q1");
      expect_at(6, S_Q1,  32'h11EE, "latency3_q1");
      expect_at(3, S_PH2, 32'h1,    "pre0_phase2");
      expect_at(4, S_PH2, 32'h1,    "pre1_phase2");
      expect_at(5, S_PH2, 32'h0,    "eval0_phase2");

      goto(3);
      d0t = 8'hA5; d0f = 8'h5A;
      expect_at(5, S_Q0, 32'h0000, "alt_pre_q0");
      expect_at(5, S_V0, 32'h0,    "alt_pre_valid0");
      expect_at(6, S_Q0, 32'hA55A, "alt_eval_q0");
      expect_at(6, S_V0, 32'h1,    "alt_eval_valid0");
      expect_at(7, S_Q0, 32'h0000, "alt_pre2_q0");
      expect_at(7, S_V0, 32'h0,    "alt_pre2_valid0");
      expect_at(8, S_Q0, 32'hA55A, "alt_eval2_q0");
      expect_at(8, S_V0, 32'h1,    "alt_eval2_valid0");

      goto(5);
      en2 = 1'b0;
      for (int i = 6; i <= 9; i++) expect_at(i, S_PH2, 32'h0, "frozen_phase2");

      goto(6);
      d1t = 8'h3C; d1f = 8'hC3;
      expect_at(9,  S_Q1, 32'h11EE, "before_switch_q1");
      expect_at(10, S_Q1, 32'h3CC3, "after_switch_q1");

      goto(8);
      d0t = 8'hA4; d0f = 8'h5A;
      expect_at(10, S_Q0,  32'hA45A, "spacer_bit_q0");
      expect_at(10, S_V0,  32'h0,    "spacer_bit_valid0");
      expect_at(10, S_FO0, 32'h0,    "spacer_not_fault0");

      goto(9);
      en2 = 1'b1;
      expect_at(10, S_PH2,  32'h0, "resume_eval1_phase2");
      expect_at(11, S_PH2,  32'h0, "resume_eval2_phase2");
      expect_at(12, S_PH2,  32'h1, "resume_pre1_phase2");
      expect_at(13, S_PH2,  32'h1, "resume_pre2_phase2");
      expect_at(14, S_PH2,  32'h0, "resume_eval_phase2");
      expect_at(14, S_CNT2, 32'h0, "no_fault_cnt2");
      expect_at(14, S_FO2,  32'h0, "no_fault_fo2");

      goto(10);
      p1 = 1'b1;
      d0t = 8'h01; d0f = 8'h01;
      expect_at(11,  S_Q1,   32'h0000, "ext_pre_q1");
      expect_at(11,  S_PH1,  32'h1,    "ext_pre_phase1");
      expect_at(11,  S_CNT0, 32'd1,    "fault_first_cnt0");
      expect_at(11,  S_FO0,  32'h1,    "fault_first_fo0");
      expect_at(12,  S_Q0,   32'h0101, "invalid_prop_q0");
      expect_at(12,  S_V0,   32'h0,    "invalid_prop_valid0");
      expect_at(264, S_CNT0, 32'd254,  "near_sat_cnt0");
      expect_at(265, S_CNT0, 32'd255,  "sat_cnt0");
      expect_at(310, S_CNT0, 32'd255,  "sat_hold_cnt0");

      goto(11);
      p1 = 1'b0;
      expect_at(12, S_Q1,  32'h3CC3, "ext_eval_again_q1");
      expect_at(12, S_PH1, 32'h0,    "ext_eval_again_phase1");

      goto(14);
      d2f = 8'hF1;
      expect_at(15, S_CNT2, 32'd1, "fault_a_cnt2");
      expect_at(15, S_FO2,  32'h1, "fault_a_fo2");
      expect_at(16, S_CNT2, 32'd2, "fault_b_cnt2");

      goto(16);
      clr2 = 1'b1;
      expect_at(17, S_CNT2, 32'd1, "set_wins_cnt2");
      expect_at(17, S_FO2,  32'h1, "set_wins_fo2");

      goto(17);
      clr2 = 1'b0;
      d2f = 8'hF0;
      expect_at(18, S_CNT2, 32'd1, "after_clr_cnt2");
      expect_at(18, S_FO2,  32'h1, "after_clr_fo2");

      goto(310);
      d0t = 8'h00; d0f = 8'hFF;
      clr0 = 1'b1;
      expect_at(311, S_CNT0, 32'd0, "clear_cnt0");
      expect_at(311, S_FO0,  32'h0, "clear_fo0");

      goto(311);
      clr0 = 1'b0;

      goto(313);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover_checks: got %0d pending expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
